// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer.
// Entry layout and pointer width function.
package sb_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] adr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over buffered stores.
// Walks back from wr_idx so the newest match wins.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = sb_ptr_w(DEPTH) - 1
) (
  input  logic [DEPTH-1:0] vld,
  input  logic [DEPTH-1:0] eq,
  input  logic [IW-1:0]    wr_idx,
  output logic             hit,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand [DEPTH];

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // oldest first, so the newest overwrites
    for (int k = DEPTH; k >= 1; k--) begin
      cand[k-1] = wr_idx - IW'(k);
      if (vld[cand[k-1]] && eq[cand[k-1]]) begin
        hit = 1'b1;
        idx = cand[k-1];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer with in-order drain
// and youngest-entry load forwarding.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_write,
  input  logic [ADDR_W-1:0]      data_adr,
  input  logic [DATA_W-1:0]      write_data,
  input  logic [ADDR_W-1:0]      ld_adr,
  output logic                   stall,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   m_valid,
  output logic [ADDR_W-1:0]      m_adr,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   m_ready,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   misaligned
);

  localparam int PW = sb_ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          mis_q, mis_d;
  sb_entry_t     mem_q [DEPTH];

  logic          full;
  logic          aligned;
  logic          push;
  logic          pop;
  sb_entry_t     new_ent;
  sb_entry_t     head;

  logic [IW-1:0]     off [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  eq;
  logic              hit;
  logic [IW-1:0]     hit_idx;
  logic              unused_ld;

  assign unused_ld = ^ld_adr[1:0];

  always_comb begin
    full    = (wr_q[IW] != rd_q[IW]) &&
              (wr_q[IW-1:0] == rd_q[IW-1:0]);
    empty   = (wr_q == rd_q);
    count   = wr_q - rd_q;
    aligned = (data_adr[1:0] == 2'b00);
    push    = mem_write & ~full & aligned;
    pop     = ~empty & m_ready;
    stall   = mem_write & full;
    wr_d    = wr_q + {{IW{1'b0}}, push};
    rd_d    = rd_q + {{IW{1'b0}}, pop};
    mis_d   = mis_q | (mem_write & ~aligned);
    new_ent.adr  = SB_ADDR_W'(data_adr);
    new_ent.data = SB_DATA_W'(write_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mis_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mis_q <= mis_d;
    end
  end

  // entry storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[IW-1:0]] <= new_ent;
  end

  always_comb begin
    head       = mem_q[rd_q[IW-1:0]];
    m_valid    = ~empty;
    m_adr      = ADDR_W'(head.adr);
    m_data     = DATA_W'(head.data);
    misaligned = mis_q;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = IW'(i) - rd_q[IW-1:0];
      vld[i] = ({1'b0, off[i]} < count);
      eq[i]  = (ADDR_W'(mem_q[i].adr) >> 2) == (ld_adr >> 2);
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .vld    (vld),
    .eq     (eq),
    .wr_idx (wr_q[IW-1:0]),
    .hit    (hit),
    .idx    (hit_idx)
  );

  always_comb begin
    fwd_hit  = hit;
    fwd_data = hit ? DATA_W'(mem_q[hit_idx].data) : '0;
  end

endmodule
